// File: rtl/alu_pkg.sv
// Opcode constants and FSM state encoding shared by the ALU scheduler and its ALU core.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Purpose: combinational W-bit ALU (add, or, sub, xor); carry and borrow are dropped.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the output follows the inputs.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_OR:   y = a | b;
            OP_SUB:  y = a - b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_sched.sv
// Purpose: round-robin arbiter over N requesters feeding one shared ALU; ALU_RR_SCHED_STATS_EN adds grant_cnt.
// Latency: response valid two cycles after the accept cycle; at best one operation per three cycles.
// Backpressure: the response is held until rsp_ready; no request is accepted until it has drained.
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter  int W   = 8,
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    input  logic [2*N-1:0]   req_op,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_out,
    input  logic             rsp_ready
`ifdef ALU_RR_SCHED_STATS_EN
    ,
    output logic [15:0]      grant_cnt
`endif
);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] gnt_q;
    logic [IDW-1:0] pick_idx;
    logic           pick_vld;
    logic           accept;
    logic [W-1:0]   a_q, b_q;
    logic [1:0]     op_q;
    logic [W-1:0]   alu_y;

    // Descending scan so the last hit is the nearest index at or after ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % N]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // req_ready is gated by rst_n so it drops immediately when reset asserts.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld && rst_n) begin
                    req_ready[pick_idx] = 1'b1;
                    accept              = 1'b1;
                    state_d             = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_RESP;
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            gnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_out   <= '0;
        end else begin
            if (accept) begin
                a_q   <= req_a[int'(pick_idx)*W +: W];
                b_q   <= req_b[int'(pick_idx)*W +: W];
                op_q  <= req_op[int'(pick_idx)*2 +: 2];
                gnt_q <= pick_idx;
            end
            if (state_q == S_EXEC) begin
                rsp_out   <= alu_y;
                rsp_id    <= gnt_q;
                rsp_valid <= 1'b1;
            end
            if (state_q == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                ptr_q     <= (gnt_q == IDW'(N - 1)) ? '0 : gnt_q + 1'b1;
            end
        end
    end

    alu_core #(.W(W)) u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

`ifdef ALU_RR_SCHED_STATS_EN
    logic [15:0] grant_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              grant_cnt_q <= '0;
        else if (accept && grant_cnt_q != 16'hFFFF) grant_cnt_q <= grant_cnt_q + 16'd1;
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Directed bench for alu_rr_sched: stimulus pushes expected results, a negedge monitor pops and compares on handshake.
module tb_alu_rr_sched;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_out;
    logic        rsp_ready;
`ifdef ALU_RR_SCHED_STATS_EN
    logic [15:0] grant_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         id;
        logic [7:0] out;
        int         acc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    bit   prev_vld = 1'b0;

    alu_rr_sched #(.W(8), .N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_ready (rsp_ready)
`ifdef ALU_RR_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on each rising rsp_valid, payload on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_vld = 1'b0;
        end else begin
            if (rsp_valid && !prev_vld) begin
                if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
                else               chk("latency", cyc - q[0].acc, 32'd2);
            end
            if (rsp_valid && rsp_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("rsp_id", 32'(rsp_id), e.id);
                chk("rsp_out", 32'(rsp_out), 32'(e.out));
            end
            prev_vld = rsp_valid;
        end
    end

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        req_a[id*8 +: 8]  = a;
        req_b[id*8 +: 8]  = b;
        req_op[id*2 +: 2] = op;
        req_valid[id]     = 1'b1;
    endtask

    task automatic wait_grant(input int exp_id, input logic [7:0] exp_out, input bit push,
                              input bit drop, output int waited);
        logic [3:0] exp_rdy;
        int n = 0;
        exp_rdy = 4'b0001 << exp_id;
        @(negedge clk);
        while (req_ready == 4'b0000 && n < 20) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        if (req_ready == 4'b0000) begin
            chk("grant_timeout", 32'd1, 32'd0);
            return;
        end
        chk("grant_onehot", 32'(req_ready), 32'(exp_rdy));
        if (push) q.push_back('{exp_id, exp_out, cyc});
        @(posedge clk);
        #1;
        if (drop) req_valid[exp_id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic [7:0] ka;
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
`ifdef ALU_RR_SCHED_STATS_EN
        chk("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        rst_n     = 1'b1;

        // Single requester, then one of each remaining opcode.
        set_req(2, 8'hF0, 8'h20, OP_ADD);
        wait_grant(2, 8'h10, 1'b1, 1'b1, w);
        drain();
        set_req(0, 8'h05, 8'h07, OP_SUB);
        wait_grant(0, 8'hFE, 1'b1, 1'b1, w);
        drain();
        set_req(1, 8'h0F, 8'hF0, OP_OR);
        wait_grant(1, 8'hFF, 1'b1, 1'b1, w);
        drain();
        set_req(3, 8'hAA, 8'hFF, OP_XOR);
        wait_grant(3, 8'h55, 1'b1, 1'b1, w);
        drain();

        // All four held valid: rotation 0,1,2,3,0,1 starting from ptr=0.
        set_req(0, 8'h01, 8'h03, OP_ADD);
        set_req(1, 8'h11, 8'h03, OP_OR);
        set_req(2, 8'h21, 8'h03, OP_SUB);
        set_req(3, 8'h31, 8'h03, OP_XOR);
        wait_grant(0, 8'h04, 1'b1, 1'b0, w);
        wait_grant(1, 8'h13, 1'b1, 1'b0, w);
        wait_grant(2, 8'h1E, 1'b1, 1'b0, w);
        wait_grant(3, 8'h32, 1'b1, 1'b0, w);
        wait_grant(0, 8'h04, 1'b1, 1'b0, w);
        wait_grant(1, 8'h13, 1'b1, 1'b0, w);
        req_valid = 4'h0;
        drain();

        // Stall the response five cycles with another requester waiting.
        rsp_ready = 1'b0;
        set_req(1, 8'h40, 8'h01, OP_ADD);
        wait_grant(1, 8'h41, 1'b1, 1'b1, w);
        set_req(0, 8'h09, 8'h01, OP_SUB);
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_id", 32'(rsp_id), 32'd1);
            chk("stall_rsp_out", 32'(rsp_out), 32'h41);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_grant(0, 8'h08, 1'b1, 1'b1, w);
        chk("resume_after_hs", 32'(w), 32'd1);
        drain();

        // Reset while the operation is in EXEC: no response, ptr back to 0.
        set_req(3, 8'h12, 8'h34, OP_ADD);
        wait_grant(3, 8'h00, 1'b0, 1'b1, w);
        rst_n = 1'b0;
        set_req(2, 8'h80, 8'h80, OP_ADD);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_exec_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(0, 8'h33, 8'h0F, OP_XOR);
        wait_grant(0, 8'h3C, 1'b1, 1'b1, w);
        wait_grant(2, 8'h00, 1'b1, 1'b1, w);
        drain();

        // Eight more operations (ptr=3), ten grants since the last reset.
        for (int k = 0; k < 8; k++) begin
            ka = 8'(k * 7);
            set_req((3 + k) % 4, ka, 8'h01, OP_ADD);
            wait_grant((3 + k) % 4, ka + 8'h01, 1'b1, 1'b1, w);
            drain();
        end
`ifdef ALU_RR_SCHED_STATS_EN
        chk("grant_cnt_10", 32'(grant_cnt), 32'd10);
        force dut.grant_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.grant_cnt_q;
        set_req(1, 8'h02, 8'h02, OP_OR);
        wait_grant(1, 8'h02, 1'b1, 1'b1, w);
        drain();
        chk("grant_cnt_sat", 32'(grant_cnt), 32'hFFFF);
`endif

        repeat (3) @(negedge clk);
        chk("queue_empty_end", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_rr_sched.md
ALU_RR_SCHED -- requirements
Module: alu_rr_sched

Interface
REQ-001 SHALL have parameter W, default 8, operand/result width in bits (W >= 1).
REQ-002 SHALL have parameter N, default 4, number of requesters (N >= 1); IDW = max(1, clog2(N)).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  N  per-requester request valid.
REQ-006 SHALL have port req_ready  output  N  per-requester accept strobe; at most one bit high per cycle.
REQ-007 SHALL have port req_a  input  N*W  operand a; requester i occupies bits [i*W +: W].
REQ-008 SHALL have port req_b  input  N*W  operand b; same packing as req_a.
REQ-009 SHALL have port req_op  input  2*N  opcode; requester i occupies bits [2i +: 2].
REQ-010 SHALL have port rsp_valid  output  1  result valid.
REQ-011 SHALL have port rsp_id  output  IDW  index of the requester that owns the result.
REQ-012 SHALL have port rsp_out  output  W  result.
REQ-013 SHALL have port rsp_ready  input  1  result consumer ready.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid is set, SHALL grant the first set index at or after ptr, scanning upward and wrapping modulo N; SHALL drive req_ready[g]=1 combinationally in that cycle; SHALL capture a, b, op and g; SHALL move to EXEC.
REQ-016 IDLE with no req_valid: SHALL keep all req_ready low and stay in IDLE.
REQ-017 EXEC: SHALL register the ALU result; SHALL move to RESP.
REQ-018 ALU opcodes SHALL be 00 add, 01 OR, 10 subtract, 11 XOR; add and subtract SHALL be modulo 2^W with carry and borrow discarded.
REQ-019 RESP: SHALL hold rsp_valid=1 and keep rsp_id and rsp_out stable until rsp_ready=1.
REQ-020 On the cycle rsp_valid and rsp_ready are both high, SHALL set ptr = (g+1) mod N and return to IDLE.
REQ-021 Latency: for a request accepted in cycle t, rsp_valid SHALL first be high in cycle t+2. Best-case throughput is one operation per 3 cycles.
REQ-022 req_ready SHALL be low in EXEC and RESP; requests arriving then SHALL wait.
REQ-023 Requesters SHALL hold req_valid and operands until granted. A valid dropped before grant is not an error and no record is kept.
REQ-024 With all N requesters continuously valid, grants SHALL rotate 0,1,...,N-1,0; no requester waits more than N-1 grants.
REQ-025 Outside RESP, rsp_valid SHALL be 0 and rsp_out/rsp_id SHALL hold their last values.

Reset
REQ-026 When rst_n=0: FSM SHALL go to IDLE, ptr=0, rsp_valid=0, rsp_out=0, rsp_id=0, req_ready=0, all asynchronously.
REQ-027 Reset during EXEC or RESP SHALL discard the in-flight operation without a response.

Configuration
REQ-028 With macro ALU_RR_SCHED_STATS_EN defined, SHALL add output grant_cnt (16 bits); it counts accepted requests, saturates at 0xFFFF and resets to 0.
REQ-029 Without ALU_RR_SCHED_STATS_EN, the port and counter SHALL be absent and behaviour is otherwise identical.

Structure
REQ-030 Opcode constants (OP_ADD, OP_OR, OP_SUB, OP_XOR) and the FSM state encoding SHALL live in a shared package, alu_pkg.
REQ-031 The combinational ALU SHALL be a sub-module, alu_core (parameter W; ports a, b, op, y); the round-robin pick logic stays inline.

Verification
REQ-032 Test: W=8, single requester 2 sends a=0xF0, b=0x20, op=00, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_id=2, rsp_out=0x10.
REQ-033 Test: subtract a=0x05, b=0x07 -> rsp_out=0xFE. OR 0x0F|0xF0 -> 0xFF. XOR 0xAA^0xFF -> 0x55.
REQ-034 Test: all 4 requesters valid continuously -> grant order 0,1,2,3,0,1; exactly one req_ready high per accept.
REQ-035 Test: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_out stay stable, req_ready stays 0; accept resumes the cycle after the handshake.
REQ-036 Test: assert rst_n=0 in EXEC -> rsp_valid never rises, ptr=0, and the next grant goes to the lowest valid index.
REQ-037 Test: with ALU_RR_SCHED_STATS_EN, 10 operations -> grant_cnt=10; forced to 0xFFFF it stays at 0xFFFF after another grant.
